cpu_control_fsm: RTL and testbench

- Parametrised successor to the 8-bit four-register control unit.
- Multi-cycle fetch/decode/execute FSM with an internal 4-entry register file of DATA_W bits, an internal ALU with Z/C flags, conditional jumps and HALT.
- Talks to a single-port external memory through a req/ready handshake.
- Sits between the program/data memory and the debug/top-level logic.

---
 rtl/cpu_control_fsm.sv | 257 +++++++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_control_fsm
//  Description : Multi-cycle fetch/decode/execute control unit with a
//                4-entry register file, Z/C flag ALU, conditional jumps,
//                HALT and a req/ready single-port memory interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_fsm #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted,
    output logic              illegal_op,
    output logic              flag_z,
    output logic              flag_c,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_IMM    = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // ALU operation field (ir[4:2] when ir[7]=1)
    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_XOR = 3'b100;
    localparam logic [2:0] C_ALU_SHL = 3'b101;
    localparam logic [2:0] C_ALU_SHR = 3'b110;
    localparam logic [2:0] C_ALU_CMP = 3'b111;

    // Non-ALU class field (ir[6:4] when ir[7]=0)
    localparam logic [2:0] C_CLS_SYS = 3'b000;
    localparam logic [2:0] C_CLS_MOV = 3'b001;
    localparam logic [2:0] C_CLS_LDI = 3'b010;
    localparam logic [2:0] C_CLS_LD  = 3'b011;
    localparam logic [2:0] C_CLS_ST  = 3'b100;
    localparam logic [2:0] C_CLS_JMP = 3'b101;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [DATA_W-1:0]   regs_q [4];
    logic [DATA_W-1:0]   regs_d [4];
    logic                z_q, z_d;
    logic                c_q, c_d;

    // Instruction fields
    logic [1:0] w_dd, w_ss, w_xx, w_yy;
    logic [2:0] w_aop, w_cls;
    assign w_dd  = ir_q[1:0];
    assign w_ss  = ir_q[6:5];
    assign w_aop = ir_q[4:2];
    assign w_cls = ir_q[6:4];
    assign w_xx  = ir_q[3:2];
    assign w_yy  = ir_q[1:0];

    // Register and immediate values viewed as memory addresses: truncate
    // when the address is narrower than a word, zero-extend otherwise.
    logic [ADDR_W-1:0] w_reg_addr [4];
    logic [ADDR_W-1:0] w_imm_addr;
    generate
        if (ADDR_W <= DATA_W) begin : g_addr_trunc
            for (genvar gi = 0; gi < 4; gi++) begin : g_reg
                assign w_reg_addr[gi] = regs_q[gi][ADDR_W-1:0];
            end
            assign w_imm_addr = mem_rdata[ADDR_W-1:0];
        end else begin : g_addr_zext
            for (genvar gi = 0; gi < 4; gi++) begin : g_reg
                assign w_reg_addr[gi] = {{(ADDR_W-DATA_W){1'b0}}, regs_q[gi]};
            end
            assign w_imm_addr = {{(ADDR_W-DATA_W){1'b0}}, mem_rdata};
        end
    endgenerate

    // ALU: r[dd] op r[ss] with carry/borrow out of an extra MSB
    logic [DATA_W-1:0] w_op_a, w_op_b, w_alu_res;
    logic [DATA_W:0]   w_sum, w_diff;
    logic              w_alu_c;
    always_comb begin
        w_op_a    = regs_q[w_dd];
        w_op_b    = regs_q[w_ss];
        w_sum     = {1'b0, w_op_a} + {1'b0, w_op_b};
        w_diff    = {1'b0, w_op_a} - {1'b0, w_op_b};
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (w_aop)
            C_ALU_ADD: begin
                w_alu_res = w_sum[DATA_W-1:0];
                w_alu_c   = w_sum[DATA_W];
            end
            C_ALU_SUB, C_ALU_CMP: begin
                w_alu_res = w_diff[DATA_W-1:0];
                w_alu_c   = w_diff[DATA_W];
            end
            C_ALU_AND: w_alu_res = w_op_a & w_op_b;
            C_ALU_OR:  w_alu_res = w_op_a | w_op_b;
            C_ALU_XOR: w_alu_res = w_op_a ^ w_op_b;
            C_ALU_SHL: begin
                w_alu_res = {w_op_a[DATA_W-2:0], 1'b0};
                w_alu_c   = w_op_a[DATA_W-1];
            end
            C_ALU_SHR: begin
                w_alu_res = {1'b0, w_op_a[DATA_W-1:1]};
                w_alu_c   = w_op_a[0];
            end
            default: ;
        endcase
    end

    // Jump condition selected by yy
    logic w_jmp_take;
    always_comb begin
        w_jmp_take = 1'b0;
        case (w_yy)
            2'b00:   w_jmp_take = 1'b1;
            2'b01:   w_jmp_take = z_q;
            2'b10:   w_jmp_take = ~z_q;
            default: w_jmp_take = c_q;
        endcase
    end

    // Next-state, datapath updates and memory/status outputs
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        regs_d     = regs_q;
        z_d        = z_q;
        c_d        = c_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        halted     = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata[7:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                if (ir_q[7]) begin
                    if (w_aop != C_ALU_CMP) begin
                        regs_d[w_dd] = w_alu_res;
                    end
                    z_d = (w_alu_res == '0);
                    c_d = w_alu_c;
                end else begin
                    case (w_cls)
                        C_CLS_SYS: if (w_yy == 2'b01) state_d = ST_HALT;
                        C_CLS_MOV: regs_d[w_xx] = regs_q[w_yy];
                        C_CLS_LDI, C_CLS_JMP: state_d = ST_IMM;
                        C_CLS_LD, C_CLS_ST:   state_d = ST_MEM;
                        default: illegal_op = 1'b1;
                    endcase
                end
            end
            ST_IMM: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                    if (w_cls == C_CLS_LDI) begin
                        regs_d[w_xx] = mem_rdata;
                    end else if (w_jmp_take) begin
                        pc_d = w_imm_addr;
                    end
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                if (w_cls == C_CLS_LD) begin
                    mem_addr = w_reg_addr[w_yy];
                end else begin
                    mem_we    = 1'b1;
                    mem_addr  = w_reg_addr[w_xx];
                    mem_wdata = regs_q[w_yy];
                end
                if (mem_ready) begin
                    state_d = ST_FETCH;
                    if (w_cls == C_CLS_LD) begin
                        regs_d[w_xx] = mem_rdata;
                    end
                end
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase

        // While reset is held every output sits at its idle value, so the
        // memory sees no request until the first cycle out of reset.
        if (!reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            halted     = 1'b0;
            illegal_op = 1'b0;
        end
    end

    // State, PC, IR, register file and flag registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign flag_z   = z_q;
    assign flag_c   = c_q;
    assign pc_out   = pc_q;
    assign dbg_data = regs_q[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_control_fsm
//  Description : Directed programs for cpu_control_fsm; expected memory
//                transactions are queued and checked by a separate monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_fsm;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       mem_ready = 1'b1;
    logic [1:0] dbg_sel   = 2'd0;
    logic       mem_req, mem_we, halted, illegal_op, flag_z, flag_c;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, pc_out, dbg_data;

    logic [7:0] mem [0:255];

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ill_cnt = 0;

    always #5 clk = ~clk;

    cpu_control_fsm #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .RESET_PC (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .halted     (halted),
        .illegal_op (illegal_op),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .pc_out     (pc_out),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    // Memory model: combinational read, write on a completed write request
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed transaction is compared against the queue
    always @(negedge clk) begin
        if (mem_req && mem_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_txn: got we=%0b addr=0x%0h, expected none", mem_we, mem_addr);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                chk("txn_we", 32'(mem_we), 32'(e.we));
                chk("txn_addr", 32'(mem_addr), 32'(e.addr));
                if (e.we) chk("txn_wdata", 32'(mem_wdata), 32'(e.wdata));
            end
        end
        if (illegal_op) ill_cnt++;
    end

    task automatic exp_rd(input int a);
        txn_t t;
        t.we = 1'b0; t.addr = 8'(a); t.wdata = 8'h00;
        exp_q.push_back(t);
    endtask

    task automatic exp_wr(input int a, input int d);
        txn_t t;
        t.we = 1'b1; t.addr = 8'(a); t.wdata = 8'(d);
        exp_q.push_back(t);
    endtask

    task automatic exp_seq(input int n);
        for (int i = 0; i < n; i++) exp_rd(i);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic put(input int a, input logic [7:0] v);
        mem[a] = v;
    endtask

    task automatic chk_reg(input string name, input int idx, input int exp);
        dbg_sel = 2'(idx);
        #1;
        chk(name, 32'(dbg_data), 32'(exp));
    endtask

    // Assert reset for two edges and clear memory; queue must be drained
    task automatic hold_reset();
        chk("txn_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        reset     = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_mem();
    endtask

    task automatic release_reset();
        ill_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Counts cycles from release until halted, bounded
    task automatic wait_halt(input string name, input int exp_cyc);
        int cyc;
        cyc = 0;
        while (!halted && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, 32'(cyc), 32'(exp_cyc));
    endtask

    // LDI r0,5 ; LDI r1,3 ; ADD r0,r1 ; HALT
    task automatic load_p1();
        put(0, 8'h20); put(1, 8'h05); put(2, 8'h24); put(3, 8'h03);
        put(4, 8'hA0); put(5, 8'h01);
    endtask

    initial begin
        clear_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        chk("rst_z", 32'(flag_z), 32'd0);
        chk("rst_c", 32'(flag_c), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        for (int i = 0; i < 4; i++) chk_reg("rst_reg", i, 0);

        // Basic program: halted on cycle 11, pc=6
        hold_reset(); load_p1(); exp_seq(6); release_reset();
        wait_halt("p1_halt_cycle", 11);
        chk("p1_pc", 32'(pc_out), 32'd6);
        chk_reg("p1_r0", 0, 8'h08);
        chk_reg("p1_r1", 1, 8'h03);
        chk("p1_z", 32'(flag_z), 32'd0);
        chk("p1_c", 32'(flag_c), 32'd0);
        chk("p1_no_illegal", 32'(ill_cnt), 32'd0);

        // ADD overflow, then reserved opcode 0x60 must leave state alone
        hold_reset();
        chk("rst_clears_halt", 32'(halted), 32'd0);
        put(0, 8'h20); put(1, 8'hFF); put(2, 8'h24); put(3, 8'h01);
        put(4, 8'hA0); put(5, 8'h60); put(6, 8'h01);
        exp_seq(7); release_reset();
        wait_halt("p2_halt_cycle", 13);
        chk_reg("p2_r0", 0, 8'h00);
        chk_reg("p2_r1", 1, 8'h01);
        chk_reg("p2_r3", 3, 8'h00);
        chk("p2_z", 32'(flag_z), 32'd1);
        chk("p2_c", 32'(flag_c), 32'd1);
        chk("p2_illegal_pulses", 32'(ill_cnt), 32'd1);
        chk("p2_pc", 32'(pc_out), 32'd7);

        // ADD overflow then CMP r0,r1: 0-1 borrows, r0 unchanged
        hold_reset();
        put(0, 8'h20); put(1, 8'hFF); put(2, 8'h24); put(3, 8'h01);
        put(4, 8'hA0); put(5, 8'hBC); put(6, 8'h01);
        exp_seq(7); release_reset();
        wait_halt("p3_halt_cycle", 13);
        chk_reg("p3_r0", 0, 8'h00);
        chk("p3_z", 32'(flag_z), 32'd0);
        chk("p3_c", 32'(flag_c), 32'd1);

        // LDI r1,37; LDI r2,81; SHL r2; SUB r1,r1; LDI r3,81; SHR r3; HALT
        hold_reset();
        put(0, 8'h24); put(1, 8'h37); put(2, 8'h28); put(3, 8'h81);
        put(4, 8'h96); put(5, 8'hA5); put(6, 8'h2C); put(7, 8'h81);
        put(8, 8'h9B); put(9, 8'h01);
        exp_seq(10); release_reset();
        wait_halt("p4_halt_cycle", 18);
        chk_reg("p4_r1_sub_self", 1, 8'h00);
        chk_reg("p4_r2_shl", 2, 8'h02);
        chk_reg("p4_r3_shr", 3, 8'h40);
        chk("p4_z", 32'(flag_z), 32'd0);
        chk("p4_c", 32'(flag_c), 32'd1);

        // LDI r0,20; LDI r1,A5; ST [r0],r1; LD r2,[r0]; HALT
        hold_reset();
        put(0, 8'h20); put(1, 8'h20); put(2, 8'h24); put(3, 8'hA5);
        put(4, 8'h41); put(5, 8'h38); put(6, 8'h01);
        exp_seq(5); exp_wr(8'h20, 8'hA5); exp_rd(5); exp_rd(8'h20); exp_rd(6);
        release_reset();
        wait_halt("p5_halt_cycle", 15);
        chk_reg("p5_r2_ld", 2, 8'hA5);
        chk("p5_mem_20", 32'(mem[8'h20]), 32'hA5);
        chk("p5_pc", 32'(pc_out), 32'd7);

        // SUB r0,r0 (Z=1); JNZ 40 not taken; JZ 40 taken; HALT at 40
        hold_reset();
        put(0, 8'h84); put(1, 8'h52); put(2, 8'h40); put(3, 8'h51);
        put(4, 8'h40); put(8'h40, 8'h01);
        exp_seq(5); exp_rd(8'h40); release_reset();
        wait_halt("p6_halt_cycle", 11);
        chk("p6_pc", 32'(pc_out), 32'h41);
        chk("p6_z", 32'(flag_z), 32'd1);

        // Fetch stalled for three cycles: request and address held
        hold_reset(); load_p1(); exp_seq(6);
        mem_ready = 1'b0;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req_held", 32'(mem_req), 32'd1);
            chk("stall_addr_held", 32'(mem_addr), 32'd0);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        wait_halt("stall_halt_cycle_after_wait", 11);
        chk_reg("stall_r0", 0, 8'h08);

        // Reset asserted while a fetch is waiting
        hold_reset(); load_p1(); exp_seq(2); release_reset();
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("midrst_waiting_addr", 32'(mem_addr), 32'd2);
        chk_reg("midrst_r0_before", 0, 8'h05);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_req_low", 32'(mem_req), 32'd0);
        chk("midrst_pc", 32'(pc_out), 32'd0);
        chk_reg("midrst_r0_cleared", 0, 8'h00);

        // JMP FF; NOP at FF; PC wraps so the next fetch is at 0
        hold_reset();
        put(0, 8'h50); put(1, 8'hFF); put(8'hFF, 8'h00);
        exp_rd(0); exp_rd(1); exp_rd(8'hFF); exp_rd(0);
        release_reset();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("wrap_pending", 32'(exp_q.size()), 32'd0);
        chk("wrap_pc", 32'(pc_out), 32'd1);
        reset = 1'b0;

        hold_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
